// File: rtl/counter_pkg.sv
// Shared definitions for the programmable counter family: boundary modes and
// a ceiling-log2 helper used to size the prescaler register.
package counter_pkg;

    localparam int unsigned CNT_MODE_WRAP = 32'd0;
    localparam int unsigned CNT_MODE_SAT  = 32'd1;

    // Number of bits needed to hold values 0..value-1 (0 for value <= 1).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 32'd0;
        for (int unsigned i = 32'd0; i < 32'd32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 32'd1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Enable prescaler: counts enabled cycles 0..PRESCALE-1 and flags the last
// phase so the parent counter steps once every PRESCALE enabled cycles.
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int unsigned PRESCALE = 32'd2
) (
    input  logic clock,
    input  logic rst,
    input  logic en,
    input  logic sync_clr,
    output logic tick
);

    localparam int unsigned PW = (clog2(PRESCALE) < 32'd1) ? 32'd1 : clog2(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 32'd1);
    localparam logic [PW-1:0] ONE  = PW'(32'd1);

    logic [PW-1:0] r_cnt;
    logic [PW-1:0] w_cnt_nxt;
    logic          w_last;

    // The tick is decoded straight from the phase register; the parent
    // qualifies it with the enable.
    assign w_last = (r_cnt == LAST);
    assign tick   = w_last;

    // Next phase: clear wins, otherwise advance on enabled cycles and
    // return to zero on the cycle that produces a step.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (sync_clr) begin
            w_cnt_nxt = {PW{1'b0}};
        end else if (en) begin
            if (w_last) begin
                w_cnt_nxt = {PW{1'b0}};
            end else begin
                w_cnt_nxt = r_cnt + ONE;
            end
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // Phase register with asynchronous reset.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_cnt <= {PW{1'b0}};
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

endmodule

// File: rtl/prog_counter.sv
// General event/timebase counter: programmable modulo, up/down, synchronous
// clear and clamped load, wrap or saturate at the boundary, optional enable
// prescaler, a terminal-count pulse and a sticky overflow flag.
module prog_counter
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH    = 32'd12,
    parameter longint unsigned MODULO   = 64'd4096,
    parameter int unsigned     SAT_MODE = CNT_MODE_WRAP,
    parameter int unsigned     PRESCALE = 32'd1
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             d_en,
    input  logic             d_up,
    input  logic             d_clr,
    input  logic             d_load,
    input  logic [WIDTH-1:0] d_load_val,
    input  logic             d_ovf_clr,
    output logic [WIDTH-1:0] d_out,
    output logic             d_tc,
    output logic             d_ovf
);

    // Reject parameter sets the counter cannot implement.
    generate
        if ((WIDTH < 32'd1) || (WIDTH > 32'd32) ||
            (MODULO < 64'd2) || (MODULO > (64'd1 << WIDTH)) ||
            (PRESCALE < 32'd1) || (SAT_MODE > CNT_MODE_SAT)) begin : g_param_check
            $error("prog_counter: illegal parameter set");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 64'd1);
    localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(32'd1);

    logic [WIDTH-1:0] r_cnt;
    logic             r_tc;
    logic             r_ovf;

    logic [WIDTH-1:0] w_cnt_nxt;
    logic             w_tc_nxt;
    logic             w_ovf_nxt;
    logic             w_tick;
    logic             w_step;
    logic             w_at_bound;
    logic             w_bound_step;

    // Without prescaling every enabled cycle is a step.
    generate
        if (PRESCALE > 32'd1) begin : g_presc
            counter_prescaler #(
                .PRESCALE (PRESCALE)
            ) u_presc (
                .clock    (clock),
                .rst      (rst),
                .en       (d_en),
                .sync_clr (d_clr | d_load),
                .tick     (w_tick)
            );
        end else begin : g_no_presc
            assign w_tick = 1'b1;
        end
    endgenerate

    assign w_step       = d_en & w_tick;
    assign w_at_bound   = d_up ? (r_cnt == MAX_VAL) : (r_cnt == ZERO);
    assign w_bound_step = w_step & w_at_bound & ~d_clr & ~d_load;

    // Next count and terminal-count pulse: clear > load > step > hold.
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_tc_nxt  = 1'b0;
        if (d_clr) begin
            w_cnt_nxt = ZERO;
        end else if (d_load) begin
            if (d_load_val > MAX_VAL) begin
                w_cnt_nxt = MAX_VAL;
            end else begin
                w_cnt_nxt = d_load_val;
            end
        end else if (w_step) begin
            if (w_at_bound) begin
                w_tc_nxt = 1'b1;
                if (SAT_MODE == CNT_MODE_SAT) begin
                    w_cnt_nxt = r_cnt;
                end else begin
                    w_cnt_nxt = d_up ? ZERO : MAX_VAL;
                end
            end else begin
                w_cnt_nxt = d_up ? (r_cnt + ONE) : (r_cnt - ONE);
            end
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // Sticky overflow: a boundary step sets it and beats a coincident clear.
    always_comb begin
        w_ovf_nxt = r_ovf;
        if (w_bound_step) begin
            w_ovf_nxt = 1'b1;
        end else if (d_ovf_clr) begin
            w_ovf_nxt = 1'b0;
        end else begin
            w_ovf_nxt = r_ovf;
        end
    end

    // Count, pulse and flag registers with asynchronous reset.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_cnt <= ZERO;
            r_tc  <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_tc  <= w_tc_nxt;
            r_ovf <= w_ovf_nxt;
        end
    end

    assign d_out = r_cnt;
    assign d_tc  = r_tc;
    assign d_ovf = r_ovf;

endmodule

// File: tb/tb_prog_counter.sv
// Directed bench for prog_counter: four instances share one stimulus bus and
// each test step checks only the instance whose configuration it targets.
module tb_prog_counter;
    import counter_pkg::*;

    logic        clock;
    logic        rst;
    logic        en;
    logic        up;
    logic        clr;
    logic        load;
    logic [11:0] load_val;
    logic        ovf_clr;

    logic [11:0] out_a;
    logic        tc_a, ovf_a;
    logic [3:0]  out_w, out_s, out_p;
    logic        tc_w, ovf_w, tc_s, ovf_s, tc_p, ovf_p;

    int n_vec;
    int n_err;

    prog_counter #(.WIDTH(32'd12), .MODULO(64'd4096), .SAT_MODE(CNT_MODE_WRAP), .PRESCALE(32'd1)) u_dut_a (
        .clock(clock), .rst(rst), .d_en(en), .d_up(up), .d_clr(clr), .d_load(load),
        .d_load_val(load_val), .d_ovf_clr(ovf_clr), .d_out(out_a), .d_tc(tc_a), .d_ovf(ovf_a));

    prog_counter #(.WIDTH(32'd4), .MODULO(64'd10), .SAT_MODE(CNT_MODE_WRAP), .PRESCALE(32'd1)) u_dut_w (
        .clock(clock), .rst(rst), .d_en(en), .d_up(up), .d_clr(clr), .d_load(load),
        .d_load_val(load_val[3:0]), .d_ovf_clr(ovf_clr), .d_out(out_w), .d_tc(tc_w), .d_ovf(ovf_w));

    prog_counter #(.WIDTH(32'd4), .MODULO(64'd10), .SAT_MODE(CNT_MODE_SAT), .PRESCALE(32'd1)) u_dut_s (
        .clock(clock), .rst(rst), .d_en(en), .d_up(up), .d_clr(clr), .d_load(load),
        .d_load_val(load_val[3:0]), .d_ovf_clr(ovf_clr), .d_out(out_s), .d_tc(tc_s), .d_ovf(ovf_s));

    prog_counter #(.WIDTH(32'd4), .MODULO(64'd10), .SAT_MODE(CNT_MODE_WRAP), .PRESCALE(32'd3)) u_dut_p (
        .clock(clock), .rst(rst), .d_en(en), .d_up(up), .d_clr(clr), .d_load(load),
        .d_load_val(load_val[3:0]), .d_ovf_clr(ovf_clr), .d_out(out_p), .d_tc(tc_p), .d_ovf(ovf_p));

    // Free-running 10 ns clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance to 1 ns past the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reset pulse across one edge, all controls idle afterwards.
    task automatic do_reset();
        en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; load_val = 12'h000; ovf_clr = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0;
        load_val = 12'h000; ovf_clr = 1'b0;
        tick();
        check("rst_out_a", 32'(out_a), 32'h0);
        check("rst_tc_a", 32'(tc_a), 32'h0);
        check("rst_ovf_w", 32'(ovf_w), 32'h0);
        rst = 1'b0;

        // 1. Asynchronous reset in the middle of a count with d_ovf set.
        load = 1'b1; load_val = 12'hFFF;
        tick();
        check("a_load_fff", 32'(out_a), 32'hFFF);
        load = 1'b0; en = 1'b1; up = 1'b1;
        tick();
        check("a_wrap_out", 32'(out_a), 32'h000);
        check("a_wrap_tc", 32'(tc_a), 32'h1);
        check("a_wrap_ovf", 32'(ovf_a), 32'h1);
        load = 1'b1; load_val = 12'h2A5;
        tick();
        check("a_load_2a5", 32'(out_a), 32'h2A5);
        check("a_load_tc", 32'(tc_a), 32'h0);
        check("a_load_ovf", 32'(ovf_a), 32'h1);
        load = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("a_async_out", 32'(out_a), 32'h000);
        check("a_async_tc", 32'(tc_a), 32'h0);
        check("a_async_ovf", 32'(ovf_a), 32'h0);
        tick();
        check("a_held_out", 32'(out_a), 32'h000);
        rst = 1'b0; en = 1'b0;

        // 2. Wrap up at MODULO=10, then wrap down from 0.
        do_reset();
        en = 1'b1; up = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            check("w_up_out", 32'(out_w), 32'(i));
            check("w_up_tc", 32'(tc_w), 32'h0);
        end
        tick();
        check("w_wrap_out", 32'(out_w), 32'h0);
        check("w_wrap_tc", 32'(tc_w), 32'h1);
        check("w_wrap_ovf", 32'(ovf_w), 32'h1);
        en = 1'b0;
        tick();
        check("w_idle_tc", 32'(tc_w), 32'h0);
        check("w_idle_out", 32'(out_w), 32'h0);
        en = 1'b1; up = 1'b0;
        tick();
        check("w_down_wrap", 32'(out_w), 32'h9);
        check("w_down_tc", 32'(tc_w), 32'h1);
        tick();
        check("w_down_8", 32'(out_w), 32'h8);
        check("w_down_tc0", 32'(tc_w), 32'h0);
        en = 1'b0;

        // 3. Saturate down from 2.
        do_reset();
        load = 1'b1; load_val = 12'h002;
        tick();
        check("s_load", 32'(out_s), 32'h2);
        load = 1'b0; up = 1'b0; en = 1'b1;
        tick(); check("s_out1", 32'(out_s), 32'h1); check("s_tc1", 32'(tc_s), 32'h0);
        tick(); check("s_out2", 32'(out_s), 32'h0); check("s_tc2", 32'(tc_s), 32'h0);
        tick(); check("s_out3", 32'(out_s), 32'h0); check("s_tc3", 32'(tc_s), 32'h1);
        tick(); check("s_out4", 32'(out_s), 32'h0); check("s_tc4", 32'(tc_s), 32'h1);
        tick(); check("s_out5", 32'(out_s), 32'h0); check("s_tc5", 32'(tc_s), 32'h1);
        check("s_ovf", 32'(ovf_s), 32'h1);
        en = 1'b0;
        tick();
        check("s_tc_off", 32'(tc_s), 32'h0);
        check("s_hold", 32'(out_s), 32'h0);

        // 4. Priority and load clamping.
        do_reset();
        load = 1'b1; load_val = 12'h005;
        tick();
        check("p_load5", 32'(out_w), 32'h5);
        clr = 1'b1; load = 1'b1; load_val = 12'h007; en = 1'b1; up = 1'b1;
        tick();
        check("p_clr_wins", 32'(out_w), 32'h0);
        clr = 1'b0; load = 1'b1; load_val = 12'h00F; en = 1'b0;
        tick();
        check("p_clamp15", 32'(out_w), 32'h9);
        load_val = 12'h00A;
        tick();
        check("p_clamp10", 32'(out_w), 32'h9);
        load_val = 12'h008;
        tick();
        check("p_load8", 32'(out_w), 32'h8);
        load = 1'b0; en = 1'b1;
        tick();
        check("p_step9", 32'(out_w), 32'h9);
        tick();
        check("p_wrap_tc", 32'(tc_w), 32'h1);
        clr = 1'b1;
        tick();
        check("p_clr_out", 32'(out_w), 32'h0);
        check("p_clr_tc", 32'(tc_w), 32'h0);
        check("p_clr_ovf", 32'(ovf_w), 32'h1);
        clr = 1'b0; en = 1'b0;

        // 5. Prescale by 3.
        do_reset();
        en = 1'b1; up = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            check("pr_out", 32'(out_p), 32'(k / 3));
        end
        for (int k = 0; k < 6; k++) begin
            en = k[0];
            tick();
            check("pr_toggle", 32'(out_p), (k == 5) ? 32'h4 : 32'h3);
        end
        en = 1'b1;
        tick(); check("pr_dir_a", 32'(out_p), 32'h4);
        up = 1'b0;
        tick(); check("pr_dir_b", 32'(out_p), 32'h4);
        tick(); check("pr_dir_c", 32'(out_p), 32'h3);
        tick(); check("pr_pre_ld", 32'(out_p), 32'h3);
        load = 1'b1; load_val = 12'h006;
        tick(); check("pr_load", 32'(out_p), 32'h6);
        load = 1'b0;
        tick(); check("pr_ld_a", 32'(out_p), 32'h6);
        tick(); check("pr_ld_b", 32'(out_p), 32'h6);
        tick(); check("pr_ld_c", 32'(out_p), 32'h5);
        check("pr_tc", 32'(tc_p), 32'h0);
        en = 1'b0;

        // 6. Overflow clear racing a boundary step.
        do_reset();
        load = 1'b1; load_val = 12'h009;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b1; ovf_clr = 1'b1;
        tick();
        check("o_race_out", 32'(out_w), 32'h0);
        check("o_race_ovf", 32'(ovf_w), 32'h1);
        en = 1'b0; ovf_clr = 1'b0;
        tick();
        check("o_sticky", 32'(ovf_w), 32'h1);
        ovf_clr = 1'b1;
        tick();
        check("o_cleared", 32'(ovf_w), 32'h0);
        ovf_clr = 1'b0;
        tick();
        check("o_stays0", 32'(ovf_w), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
